// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream
//   Streaming 2x2 / stride-2 max-pooling stage. It consumes a row-major
//   element stream (valid/data, no backpressure) and emits one pooled word
//   per completed 2x2 window. One row of horizontal pair maxima is kept in
//   an internal line buffer, so no read-back of earlier rows is needed.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   clear     synchronous frame restart; zeroes position, drops same-cycle DI
//   w         feature-map width in elements (even). Only the low 10 bits are
//             carried, so a width of 1024 is encoded as 0; w-1 then wraps
//             to 1023, which is exactly the last column.
//   DI_valid  input element strobe
//   DI        input element, two's-complement signed
//   DO_valid  one-cycle pulse, pooled result on DO
//   DO        pooled result, holds between pulses
//   busy      a window is partially accumulated (position != row 0, col 0)
module maxpool2x2_stream #(
    parameter int WORD_SIZE = 16,
    parameter int MAX_W     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [9:0]           w,
    input  logic                 DI_valid,
    input  logic [WORD_SIZE-1:0] DI,
    output logic                 DO_valid,
    output logic [WORD_SIZE-1:0] DO,
    output logic                 busy
);

    localparam int DEPTH = MAX_W / 2;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [WORD_SIZE-1:0] smax(
        input logic [WORD_SIZE-1:0] a,
        input logic [WORD_SIZE-1:0] b
    );
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    logic [9:0]           col_q, col_d;
    logic                 row_odd_q, row_odd_d;
    logic [WORD_SIZE-1:0] hold_q, hold_d;
    logic [WORD_SIZE-1:0] do_q, do_d;
    logic                 do_valid_q, do_valid_d;
    logic                 busy_q, busy_d;

    // Line buffer: never reset; every entry is written in an even row before
    // the odd row reads it. Within a cycle only one of read/write happens,
    // chosen by row parity, so there is no same-index read/write conflict.
    logic [WORD_SIZE-1:0] linebuf_q [DEPTH];
    logic                 lb_we;
    logic [WORD_SIZE-1:0] lb_wdata;
    logic [IDX_W-1:0]     lb_idx;
    logic [WORD_SIZE-1:0] lb_rdata;
    logic [9:0]           w_last;

    assign lb_idx   = IDX_W'(col_q >> 1);
    assign lb_rdata = linebuf_q[lb_idx];
    assign w_last   = w - 10'd1;

    always_comb begin
        col_d      = col_q;
        row_odd_d  = row_odd_q;
        hold_d     = hold_q;
        do_d       = do_q;
        do_valid_d = 1'b0;
        lb_we      = 1'b0;
        lb_wdata   = smax(hold_q, DI);

        if (clear) begin
            col_d     = '0;
            row_odd_d = 1'b0;
        end else if (DI_valid) begin
            unique case ({row_odd_q, col_q[0]})
                2'b00: hold_d = DI;
                2'b01: lb_we  = 1'b1;
                2'b10: hold_d = smax(lb_rdata, DI);
                2'b11: begin
                    do_d       = smax(hold_q, DI);
                    do_valid_d = 1'b1;
                end
            endcase

            if (col_q == w_last) begin
                col_d     = '0;
                row_odd_d = ~row_odd_q;
            end else begin
                col_d = col_q + 10'd1;
            end
        end

        busy_d = (col_d != '0) || row_odd_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            row_odd_q  <= 1'b0;
            hold_q     <= '0;
            do_q       <= '0;
            do_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_odd_q  <= row_odd_d;
            hold_q     <= hold_d;
            do_q       <= do_d;
            do_valid_q <= do_valid_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) linebuf_q[lb_idx] <= lb_wdata;
    end

    assign DO_valid = do_valid_q;
    assign DO       = do_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
module tb_maxpool2x2_stream;

    localparam int WS    = 16;
    localparam int MAX_W = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic [9:0]    w = 10'd4;
    logic          DI_valid = 1'b0;
    logic [WS-1:0] DI = '0;
    logic          DO_valid;
    logic [WS-1:0] DO;
    logic          busy;

    maxpool2x2_stream #(.WORD_SIZE(WS), .MAX_W(MAX_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .w(w),
        .DI_valid(DI_valid), .DI(DI),
        .DO_valid(DO_valid), .DO(DO), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [WS-1:0] val; int cyc; } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every output pulse must match the oldest expectation
    // both in value and in the cycle it appears.
    always @(negedge clk) begin
        if (rst && DO_valid) begin
            if (sb.size() == 0) chk("spurious_out", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("do_val", 32'(DO), 32'(e.val));
                chk("do_lat", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    function automatic int elem(input int mode, input int wid, input int r, input int c);
        case (mode)
            0: return r * wid + c;
            1: case (r * 2 + c)
                   0: return -3;
                   1: return -1;
                   2: return -8;
                   default: return -2;
               endcase
            default: return (r == 0) ? c : c + 1000;
        endcase
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Drive up to nmax elements of a frame; idle gaps of 0..idle_max cycles.
    // Caller is positioned just after a rising edge.
    task automatic feed(input int wid, input int rows, input int mode,
                        input int nmax, input int idle_max);
        int n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < wid; c++) begin
                if (n == nmax) return;
                n++;
                DI_valid = 1'b1;
                DI = WS'(elem(mode, wid, r, c));
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    exp_t e;
                    e.val = WS'(max2(max2(elem(mode, wid, r-1, c-1), elem(mode, wid, r-1, c)),
                                     max2(elem(mode, wid, r, c-1), elem(mode, wid, r, c))));
                    e.cyc = cyc + 1;
                    sb.push_back(e);
                end
                @(posedge clk); #1;
                DI_valid = 1'b0;
                DI = WS'(16'hDEAD);
                if (idle_max > 0) begin
                    repeat ($urandom_range(idle_max, 0)) begin @(posedge clk); #1; end
                end
            end
        end
    endtask

    task automatic pulse_clear(input logic with_data);
        clear = 1'b1;
        DI_valid = with_data;
        DI = WS'(99);
        @(posedge clk); #1;
        clear = 1'b0;
        DI_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 20) begin @(posedge clk); #1; k++; end
        chk(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #12;
        chk("rst_do_valid", 32'(DO_valid), 32'd0);
        chk("rst_do", 32'(DO), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 4x4 frame, back-to-back
        feed(4, 4, 0, 1000, 0);
        chk("busy_end_4x4", 32'(busy), 32'd0);
        drain("drain_4x4");

        // signed compare, w=2
        w = 10'd2;
        pulse_clear(1'b0);
        feed(2, 2, 1, 1000, 0);
        drain("drain_signed");

        // 4x4 with random idle gaps
        w = 10'd4;
        pulse_clear(1'b0);
        feed(4, 4, 0, 1000, 3);
        chk("busy_end_idle", 32'(busy), 32'd0);
        drain("drain_idle");

        // partial frame, clear with data, fresh frame
        feed(4, 4, 0, 6, 0);
        chk("busy_partial", 32'(busy), 32'd1);
        drain("drain_partial");
        pulse_clear(1'b1);
        chk("busy_after_clear", 32'(busy), 32'd0);
        feed(4, 4, 0, 1000, 0);
        chk("busy_end_clear", 32'(busy), 32'd0);
        drain("drain_clear");

        // asynchronous reset mid-frame
        feed(4, 4, 0, 13, 0);
        drain("drain_pre_rst");
        chk("busy_pre_rst", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_do_valid", 32'(DO_valid), 32'd0);
        chk("arst_do", 32'(DO), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        feed(4, 4, 0, 1000, 0);
        drain("drain_post_rst");

        // full width: 1024 is carried as 0 on the 10-bit width port
        w = 10'(MAX_W);
        pulse_clear(1'b0);
        feed(MAX_W, 2, 2, 100000, 0);
        chk("busy_end_wide", 32'(busy), 32'd0);
        drain("drain_wide");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
